// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, memory-wait freeze with timeout, branch flush.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int FLUSH_CYC   = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam bit         FLUSH_MULTI = (FLUSH_CYC > 1);
  localparam logic [7:0] FLUSH_INIT  = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] TIMEOUT_LST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic       set_err;
  logic       load_use;
  logic       mem_stall;

  assign load_use  = ex_is_load && ((id_use_a && (id_rs_a == ex_rd)) ||
                                    (id_use_b && (id_rs_b == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      timer   <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      if (set_err) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    set_err = 1'b0;
    case (state)
      RUN: begin
        if (br_taken) begin
          if (FLUSH_MULTI) begin
            state_n = FLUSH;
            timer_n = FLUSH_INIT;
          end
        end else if (mem_stall) begin
          state_n = MEM_WAIT;
          timer_n = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_n = RUN;
        end else if (timer == TIMEOUT_LST) begin
          state_n = RUN;
          set_err = 1'b1;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      FLUSH: begin
        // timer holds the FLUSH cycles still owed (the RUN cycle already flushed once),
        // so leaving as it reaches zero gives FLUSH_CYC flush cycles in total.
        timer_n = timer - 8'd1;
        if (timer_n == '0) state_n = RUN;
      end
      default: begin
        state_n = RUN;
        timer_n = '0;
      end
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    flush       = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (br_taken) begin
            flush = 1'b1;
          end else if (mem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            pipe_freeze = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          pipe_freeze = 1'b1;
        end
        FLUSH: flush = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             flush_evt;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign flush_evt = (state == RUN) && br_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
